// File: rtl/battleship_torpedo_aimer_if.sv
// Purpose : bundle of the player-control inputs and the torpedo/overlay outputs of the aimer.
// Latency : none (wires only).
// Backpr. : torp_valid/torp_ready handshake; the aimer holds torps until torp_ready.
// Ports   : master = aimer side (drives torps/overlay), slave = player + sinker side.
interface battleship_torpedo_aimer_if #(
   parameter int NSEG   = 28,
   parameter int SHOT_W = 5
);
   logic              clear;
   logic              turn_en;
   logic              btn_next;
   logic              btn_prev;
   logic              btn_fire;
   logic              torp_ready;
   logic [NSEG-1:0]   torps;
   logic              torp_valid;
   logic [NSEG-1:0]   cursor_mask;
   logic [NSEG-1:0]   fired_map;
   logic [SHOT_W-1:0] shot_count;
   logic              dup_shot;

   modport master (
      input  clear, turn_en, btn_next, btn_prev, btn_fire, torp_ready,
      output torps, torp_valid, cursor_mask, fired_map, shot_count, dup_shot
   );

   modport slave (
      output clear, turn_en, btn_next, btn_prev, btn_fire, torp_ready,
      input  torps, torp_valid, cursor_mask, fired_map, shot_count, dup_shot
   );
endinterface

// File: rtl/battleship_torpedo_aimer.sv
// Purpose : steps a cursor over the board segments, fires one torpedo per turn, refuses repeats.
// Latency : fire pulse -> torp_valid one cycle later; all outputs registered.
// Backpr. : torps/torp_valid held stable in ISSUE until torp_ready; buttons ignored meanwhile.
// Ports   : clk, reset (async active-high); bus = master modport of battleship_torpedo_aimer_if
//           (clear, turn_en, btn_* in; torps, torp_valid, cursor_mask, fired_map, shot_count, dup_shot out).
module battleship_torpedo_aimer #(
   parameter int NSEG      = 28,
   parameter int BLINK_DIV = 25_000_000,
   parameter int SHOT_W    = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   battleship_torpedo_aimer_if.master    bus
);
   localparam int CW = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [CW-1:0]   LAST_SEG = CW'(NSEG - 1);
   localparam logic [BW-1:0]   LAST_CNT = BW'(BLINK_DIV - 1);
   localparam logic [NSEG-1:0] ONE      = NSEG'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_AIM, ST_ISSUE} state_t;

   state_t            r_state,      w_state_nxt;
   logic [CW-1:0]     r_cursor,     w_cursor_nxt;
   logic [NSEG-1:0]   r_torps,      w_torps_nxt;
   logic              r_torp_valid, w_torp_valid_nxt;
   logic [NSEG-1:0]   r_fired_map,  w_fired_map_nxt;
   logic [SHOT_W-1:0] r_shot_count, w_shot_count_nxt;
   logic              r_dup_shot,   w_dup_shot_nxt;
   logic [NSEG-1:0]   r_cursor_mask, w_cursor_mask_nxt;
   logic [BW-1:0]     r_blink_cnt,  w_blink_cnt_nxt;
   logic              r_phase,      w_phase_nxt;
   logic              w_blink_adv;
   logic              w_blink_restart;
   logic [NSEG-1:0]   w_cursor_oh;

   assign w_cursor_oh = ONE << r_cursor;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cursor      <= '0;
         r_torps       <= '0;
         r_torp_valid  <= 1'b0;
         r_fired_map   <= '0;
         r_shot_count  <= '0;
         r_dup_shot    <= 1'b0;
         r_cursor_mask <= '0;
         r_blink_cnt   <= '0;
         r_phase       <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_cursor      <= w_cursor_nxt;
         r_torps       <= w_torps_nxt;
         r_torp_valid  <= w_torp_valid_nxt;
         r_fired_map   <= w_fired_map_nxt;
         r_shot_count  <= w_shot_count_nxt;
         r_dup_shot    <= w_dup_shot_nxt;
         r_cursor_mask <= w_cursor_mask_nxt;
         r_blink_cnt   <= w_blink_cnt_nxt;
         r_phase       <= w_phase_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_cursor_nxt      = r_cursor;
      w_torps_nxt       = r_torps;
      w_torp_valid_nxt  = r_torp_valid;
      w_fired_map_nxt   = r_fired_map;
      w_shot_count_nxt  = r_shot_count;
      w_dup_shot_nxt    = 1'b0;
      w_blink_cnt_nxt   = r_blink_cnt;
      w_phase_nxt       = r_phase;
      w_cursor_mask_nxt = '0;
      w_blink_adv       = 1'b0;
      w_blink_restart   = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (bus.turn_en) begin
               w_state_nxt     = ST_AIM;
               w_blink_restart = 1'b1;
            end
         end
         ST_AIM: begin
            if (!bus.turn_en) begin
               w_state_nxt = ST_IDLE;
            end else if (bus.btn_fire) begin
               // Fire wins over any move pressed in the same cycle.
               if (r_fired_map[r_cursor]) begin
                  w_dup_shot_nxt = 1'b1;
                  w_blink_adv    = 1'b1;
               end else begin
                  w_state_nxt      = ST_ISSUE;
                  w_torps_nxt      = w_cursor_oh;
                  w_torp_valid_nxt = 1'b1;
               end
            end else if (bus.btn_next && !bus.btn_prev) begin
               w_cursor_nxt    = (r_cursor == LAST_SEG) ? '0 : r_cursor + 1'b1;
               w_blink_restart = 1'b1;
            end else if (bus.btn_prev && !bus.btn_next) begin
               w_cursor_nxt    = (r_cursor == '0) ? LAST_SEG : r_cursor - 1'b1;
               w_blink_restart = 1'b1;
            end else begin
               w_blink_adv = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (r_torp_valid && bus.torp_ready) begin
               w_state_nxt      = ST_IDLE;
               w_torps_nxt      = '0;
               w_torp_valid_nxt = 1'b0;
               w_fired_map_nxt  = r_fired_map | w_cursor_oh;
               if (r_shot_count != '1) begin
                  w_shot_count_nxt = r_shot_count + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Restart shows the cursor immediately; otherwise the half-period counter runs.
      if (w_blink_restart) begin
         w_blink_cnt_nxt = '0;
         w_phase_nxt     = 1'b1;
      end else if (w_blink_adv) begin
         if (r_blink_cnt == LAST_CNT) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = ~r_phase;
         end else begin
            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
         end
      end

      // New-game clear outranks everything decided above.
      if (bus.clear) begin
         w_state_nxt      = ST_IDLE;
         w_cursor_nxt     = '0;
         w_torps_nxt      = '0;
         w_torp_valid_nxt = 1'b0;
         w_fired_map_nxt  = '0;
         w_shot_count_nxt = '0;
         w_dup_shot_nxt   = 1'b0;
         w_blink_cnt_nxt  = '0;
         w_phase_nxt      = 1'b1;
      end

      // Overlay is derived from next-cycle state so it lines up with the registered state.
      unique case (w_state_nxt)
         ST_ISSUE: w_cursor_mask_nxt = ONE << w_cursor_nxt;
         ST_AIM:   w_cursor_mask_nxt = w_phase_nxt ? (ONE << w_cursor_nxt) : '0;
         default:  w_cursor_mask_nxt = '0;
      endcase
   end

   assign bus.torps       = r_torps;
   assign bus.torp_valid  = r_torp_valid;
   assign bus.cursor_mask = r_cursor_mask;
   assign bus.fired_map   = r_fired_map;
   assign bus.shot_count  = r_shot_count;
   assign bus.dup_shot    = r_dup_shot;
endmodule
